seq_mult_hs: RTL
================

# seq_mult_hs

Parametrised sequential shift-add multiplier with per-operand signed/unsigned mode and valid/ready handshakes on both operand and result sides. One radix-2 iteration per clock, N iterations per product, result held until consumed. Drop-in successor to the fixed-width, free-running shift-right multiplier in the lab arithmetic datapath. It is intended for bus-attached accelerators where the producer and the consumer may both stall.

## Interface
- N, 32, operand width in bits; legal range N >= 2.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand set valid.
- in_ready  out  1  block can accept operands; high only in IDLE.
- a  in  N  multiplicand.
- b  in  N  multiplier.
- a_signed  in  1  1: a is two's complement; 0: a is unsigned.
- b_signed  in  1  1: b is two's complement; 0: b is unsigned.
- out_valid  out  1  p holds a finished product.
- out_ready  in  1  consumer accepts p.
- p  out  2N  product.
- busy  out  1  high in RUN.

## Operation
- States:
  - IDLE: in_ready=1.
  - RUN: N iterations.
  - DONE: out_valid=1.
- Transitions:
  - IDLE->RUN on in_valid && in_ready.
  - RUN->DONE when the iteration counter reaches N.
  - DONE->IDLE on out_valid && out_ready.
  - No other transitions.
- Capture at accept:
  - a extended to N+1 bits: sign-extend if a_signed, else zero-extend.
  - b loaded into the low half of the shift register.
  - Upper accumulator (N+1 bits) cleared.
  - Mode bits latched.
  - Counter set to 0.
- Each RUN cycle (LSB = current low bit of shift register):
  - Iterations 0..N-2: if LSB=1, acc = acc + a_ext; else acc unchanged.
  - Iteration N-1: if LSB=1 and b_signed=1, acc = acc - a_ext (weight -2^(N-1)); if LSB=1 and b_signed=0, acc = acc + a_ext.
  - Then arithmetic-shift {acc, shift_reg} right by one. The acc MSB is replicated. The arithmetic must be N+2 bits wide so no carry is lost.
- After N iterations, p = low 2N bits of {acc, shift_reg}.
  - This is the exact product for all four mode combinations.
  - Interpret p as signed if a_signed|b_signed, else unsigned.
  - The product fits in 2N bits in every mode.
- Operands on a, b, a_signed, b_signed are don't-care except on the accept edge. Changes during RUN/DONE have no effect.
- in_valid while not IDLE is ignored. No queueing; the producer must hold in_valid until in_ready.
- In DONE, p and out_valid stay stable until accepted. out_ready outside DONE is ignored.
- p retains its last value in IDLE and RUN. Consumers qualify p with out_valid only.

## Timing
- Reset value of every output:
  - State IDLE.
  - in_ready=1, out_valid=0, busy=0, p=0, counter=0.
  - Reset asserted in any state, including mid-RUN, aborts immediately. Partial results are discarded.
- Latency: operands accepted at edge T0; out_valid rises after edge TN (N cycles).
- Result accepted at the first edge Tk (k >= N+1) with out_ready=1. in_ready rises after that edge.
- Throughput: with in_valid and out_ready held high, one product every N+2 cycles. Operand and result acceptance never coincide in the same cycle.
- busy is high for exactly N cycles per operation.
- All outputs are registered or decoded directly from state. There is no combinational path from in_valid or out_ready to any output.

## Test plan
- N=8, a=0x80, b=0x80, both signed -> p=0x4000 after exactly 8 cycles; busy high for 8 cycles.
- N=8, a=0xFF, b=0xFF, both unsigned -> p=0xFE01. Repeat both signed -> p=0x0001.
- N=8 mixed modes:
  - a=0xFF signed, b=0xFF unsigned -> p=0xFF01.
  - a=0xFF unsigned, b=0xFF signed -> p=0xFF01.
  - a=0x05 signed, b=0xFD signed -> p=0xFFF1.
- Backpressure, N=8:
  - out_ready low for 5 cycles after out_valid -> p and out_valid stable throughout, in_ready=0.
  - Set in_valid=1 with new operands during RUN/DONE -> ignored; the first product is unchanged.
  - Release out_ready -> IDLE, then the new operands are accepted.
- Reset mid-RUN: drop rst_n at iteration 4, asynchronously between edges -> outputs immediately at reset values. After release, a fresh a=3, b=7 unsigned -> p=0x0015.
- Streaming, N=32: 1000 random operand/mode sets with in_valid and out_ready high. Every p must match the golden product. Spacing between out_valid rises must be exactly 34 cycles.

Source files
------------

// File: rtl/seq_mult_hs_if.sv
// -----------------------------------------------------------------------------
// seq_mult_hs_if
//   Operand and result handshake bundle for seq_mult_hs.
//
//   Operand side : in_valid / in_ready, a, b, a_signed, b_signed
//   Result side  : out_valid / out_ready, p
//   Status       : busy
//
//   master : the producer/consumer environment (drives operands, out_ready)
//   slave  : the multiplier (drives in_ready, out_valid, p, busy)
// -----------------------------------------------------------------------------
interface seq_mult_hs_if #(
  parameter int N = 32
);
  logic           in_valid;
  logic           in_ready;
  logic [N-1:0]   a;
  logic [N-1:0]   b;
  logic           a_signed;
  logic           b_signed;
  logic           out_valid;
  logic           out_ready;
  logic [2*N-1:0] p;
  logic           busy;

  modport master (
    output in_valid, a, b, a_signed, b_signed, out_ready,
    input  in_ready, out_valid, p, busy
  );

  modport slave (
    input  in_valid, a, b, a_signed, b_signed, out_ready,
    output in_ready, out_valid, p, busy
  );
endinterface

// File: rtl/seq_mult_hs.sv
// -----------------------------------------------------------------------------
// seq_mult_hs
//   Radix-2 sequential shift-add multiplier, N iterations per product, with
//   independent signed/unsigned mode per operand and valid/ready handshakes on
//   both the operand and the result side.
//
//   Ports
//     clk    : rising-edge clock
//     rst_n  : asynchronous active-low reset; aborts any operation in flight
//     bus    : seq_mult_hs_if.slave
//              in_valid/in_ready  operand handshake (in_ready high only in IDLE)
//              a, b               multiplicand / multiplier, N bits
//              a_signed/b_signed  1 = two's complement, 0 = unsigned
//              out_valid/out_ready result handshake (out_valid high only in DONE)
//              p                  2N-bit product, held until the next result
//              busy               high while iterating (exactly N cycles)
//
//   Timing: operands accepted at edge T0, out_valid rises after edge TN, the
//   result is consumed at the first later edge with out_ready high. Operand
//   and result acceptance are mutually exclusive, so back-to-back streaming
//   gives one product every N+2 cycles. Every output is a register, so there
//   is no combinational path from in_valid or out_ready to any output.
// -----------------------------------------------------------------------------
module seq_mult_hs #(
  parameter int N = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  seq_mult_hs_if.slave bus
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t state;

  // Datapath registers.
  //   a_ext : multiplicand extended to N+1 bits according to a_signed, so the
  //           a mode is fully folded in at capture and need not be latched.
  //   acc   : upper accumulator (N+1 bits, two's complement).
  //   sreg  : multiplier shifting out LSB-first while product bits shift in.
  //   b_sgn : latched b mode; selects subtract on the final iteration, where
  //           the multiplier MSB carries weight -2^(N-1).
  logic [N:0]    a_ext;
  logic [N:0]    acc;
  logic [N-1:0]  sreg;
  logic          b_sgn;
  logic [CW-1:0] cnt;

  // Iteration datapath.
  logic          last_iter;
  logic [N+1:0]  addend;
  logic [N+1:0]  sum;
  logic [N:0]    acc_nxt;
  logic [N-1:0]  sreg_nxt;

  // NOTE: every variable assigned in an always_comb gets a default first, so
  // no path through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    last_iter = (cnt == CW'(N - 1));
    addend    = '0;
    if (sreg[0]) begin
      addend = {a_ext[N], a_ext};
    end
    // N+2-bit arithmetic: acc +/- a_ext can exceed the N+1-bit range by one
    // bit, and that extra bit is exactly what the right shift keeps.
    if (last_iter && b_sgn) begin
      sum = {acc[N], acc} - addend;
    end else begin
      sum = {acc[N], acc} + addend;
    end
    // Arithmetic right shift of {sum, sreg}: the sum's top bit becomes the
    // new acc MSB, and the bit falling off the sum enters sreg at the top.
    acc_nxt  = sum[N+1:1];
    sreg_nxt = {sum[0], sreg[N-1:1]};
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of every other register.
  // NOTE: the datapath registers are reset along with the control state; the
  // block is small, and it keeps simulation free of X before the first accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      a_ext         <= '0;
      acc           <= '0;
      sreg          <= '0;
      b_sgn         <= 1'b0;
      cnt           <= '0;
      bus.in_ready  <= 1'b1;
      bus.out_valid <= 1'b0;
      bus.busy      <= 1'b0;
      bus.p         <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.in_valid) begin
            a_ext        <= bus.a_signed ? {bus.a[N-1], bus.a} : {1'b0, bus.a};
            sreg         <= bus.b;
            acc          <= '0;
            b_sgn        <= bus.b_signed;
            cnt          <= '0;
            state        <= S_RUN;
            bus.in_ready <= 1'b0;
            bus.busy     <= 1'b1;
          end
        end

        S_RUN: begin
          acc  <= acc_nxt;
          sreg <= sreg_nxt;
          cnt  <= cnt + CW'(1);
          if (last_iter) begin
            // The product fits in 2N bits in every mode, so acc's extra
            // sign bit is redundant and dropped here.
            bus.p         <= {acc_nxt[N-1:0], sreg_nxt};
            bus.out_valid <= 1'b1;
            bus.busy      <= 1'b0;
            state         <= S_DONE;
          end
        end

        S_DONE: begin
          // p and out_valid hold until consumed; operands presented now are
          // ignored because acceptance only happens from IDLE.
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            bus.in_ready  <= 1'b1;
            state         <= S_IDLE;
          end
        end

        default: begin
          state         <= S_IDLE;
          bus.in_ready  <= 1'b1;
          bus.out_valid <= 1'b0;
          bus.busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
